orv64_irf_wb_arb: RTL and testbench

//  Writeback arbiter directly upstream of the integer regfile write port.

---
 rtl/orv64_irf_wb_arb.sv | 136 +++++++++++++
 tb/tb_orv64_irf_wb_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/orv64_irf_wb_arb.sv
// Integer regfile writeback arbiter: merges MA-stage writes with buffered
// long-latency completions and tracks destinations with an LL op in flight.
module orv64_irf_wb_arb #(
  parameter int XLEN     = 64,
  parameter int AW       = 5,
  parameter int LL_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ma_we,
  input  logic [AW-1:0]        ma_rd_addr,
  input  logic [XLEN-1:0]      ma_rd,
  input  logic                 ll_iss_vld,
  input  logic [AW-1:0]        ll_iss_addr,
  input  logic                 ll_vld,
  output logic                 ll_rdy,
  input  logic [AW-1:0]        ll_addr,
  input  logic [XLEN-1:0]      ll_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [XLEN-1:0]      rf_wd,
  output logic [2**AW-1:0]     busy,
  output logic                 wb_stall
);

  localparam int PW   = $clog2(LL_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**AW;

  logic [AW-1:0]   addr_mem [LL_DEPTH];
  logic [XLEN-1:0] data_mem [LL_DEPTH];

  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            full, empty;

  logic            ma_sel, ll_push_cand, pop, bypass, push;
  logic            rf_we_next;
  logic [AW-1:0]   rf_wa_next;
  logic [XLEN-1:0] rf_wd_next;
  logic            ll_wr;
  logic [AW-1:0]   ll_wr_addr;

  logic [NREG-1:0] busy_reg, busy_next, set_vec, clr_vec;

  assign full     = (count_reg == CW'(LL_DEPTH));
  assign empty    = (count_reg == '0);
  assign ll_rdy   = ~full & ~rst;
  assign wb_stall = full & ~rst;
  assign busy     = busy_reg;

  // x0 destinations are handshaken but never stored or written.
  assign ma_sel       = ma_we & (ma_rd_addr != '0);
  assign ll_push_cand = ll_vld & ll_rdy & (ll_addr != '0);
  assign pop          = ~ma_sel & ~empty;
  assign bypass       = ~ma_sel & empty & ll_push_cand;
  assign push         = ll_push_cand & ~bypass;

  always_comb begin
    rf_we_next = 1'b0;
    rf_wa_next = rf_wa;
    rf_wd_next = rf_wd;
    ll_wr      = 1'b0;
    ll_wr_addr = '0;
    if (ma_sel) begin
      rf_we_next = 1'b1;
      rf_wa_next = ma_rd_addr;
      rf_wd_next = ma_rd;
    end else if (pop) begin
      rf_we_next = 1'b1;
      rf_wa_next = addr_mem[rd_ptr_reg];
      rf_wd_next = data_mem[rd_ptr_reg];
      ll_wr      = 1'b1;
      ll_wr_addr = addr_mem[rd_ptr_reg];
    end else if (bypass) begin
      rf_we_next = 1'b1;
      rf_wa_next = ll_addr;
      rf_wd_next = ll_data;
      ll_wr      = 1'b1;
      ll_wr_addr = ll_addr;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Set wins over a same-edge clear so a back-to-back reissue stays tracked.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      assign set_vec[gi]   = (gi != 0) & ll_iss_vld & (ll_iss_addr == AW'(gi));
      assign clr_vec[gi]   = ll_wr & (ll_wr_addr == AW'(gi));
      assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= ll_addr;
      data_mem[wr_ptr_reg] <= ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      busy_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      rf_we     <= rf_we_next;
      rf_wa     <= rf_wa_next;
      rf_wd     <= rf_wd_next;
      busy_reg  <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ll_iss_vld && (ll_iss_addr != '0)) begin
      assert (!busy_reg[ll_iss_addr] || clr_vec[ll_iss_addr])
        else $error("orv64_irf_wb_arb: LL issue to already-busy x%0d", ll_iss_addr);
    end
  end

endmodule

// File: tb/tb_orv64_irf_wb_arb.sv
// Directed and randomized checks of orv64_irf_wb_arb against a queue-based
// reference model of the writeback priority and busy scoreboard.
module tb_orv64_irf_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ma_we;
  logic [4:0]  ma_rd_addr;
  logic [63:0] ma_rd;
  logic        ll_iss_vld;
  logic [4:0]  ll_iss_addr;
  logic        ll_vld;
  logic        ll_rdy;
  logic [4:0]  ll_addr;
  logic [63:0] ll_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [31:0] busy;
  logic        wb_stall;

  orv64_irf_wb_arb #(.XLEN(64), .AW(5), .LL_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ma_we(ma_we), .ma_rd_addr(ma_rd_addr), .ma_rd(ma_rd),
    .ll_iss_vld(ll_iss_vld), .ll_iss_addr(ll_iss_addr),
    .ll_vld(ll_vld), .ll_rdy(ll_rdy), .ll_addr(ll_addr), .ll_data(ll_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy(busy), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [63:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  bit          last_rdy, last_stall;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; ma_we = 1'b0; ma_rd_addr = '0; ma_rd = '0;
    ll_iss_vld = 1'b0; ll_iss_addr = '0;
    ll_vld = 1'b0; ll_addr = '0; ll_data = '0;
  endtask

  // One clock: check handshake outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit rdy, acc, byp;
    logic [31:0] clr;
    ent_t e;
    #1;
    rdy = !rst && (q.size() < 2);
    chk("ll_rdy", ll_rdy, rdy);
    chk("wb_stall", wb_stall, !rst && (q.size() == 2));
    last_rdy = rdy;
    last_stall = !rst && (q.size() == 2);
    if (rst) begin
      q.delete(); m_busy = '0; m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      acc = ll_vld && rdy; clr = '0; byp = 0;
      if (ma_we && ma_rd_addr != 0) begin
        m_we = 1; m_wa = ma_rd_addr; m_wd = ma_rd;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1; m_wa = e.a; m_wd = e.d; clr[e.a] = 1'b1;
      end else if (acc && ll_addr != 0) begin
        m_we = 1; m_wa = ll_addr; m_wd = ll_data; clr[ll_addr] = 1'b1; byp = 1;
      end else begin
        m_we = 0;
      end
      if (acc && ll_addr != 0 && !byp) begin
        e.a = ll_addr; e.d = ll_data; q.push_back(e);
      end
      m_busy = m_busy & ~clr;
      if (ll_iss_vld && ll_iss_addr != 0) m_busy[ll_iss_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
    chk("busy", busy, m_busy);
  endtask

  initial begin
    q.delete(); m_busy = '0; m_we = 0; m_wa = '0; m_wd = '0;
    set_idle();
    rst = 1'b1;
    cycle(); cycle();
    chk("reset_we", rf_we, 0);
    chk("reset_busy", busy, 0);
    set_idle();

    // 1: MA writeback, one cycle latency
    ma_we = 1; ma_rd_addr = 5; ma_rd = 64'hA5;
    cycle();
    chk("t1_we", rf_we, 1); chk("t1_wa", rf_wa, 5); chk("t1_wd", rf_wd, 64'hA5);
    chk("t1_busy", busy, 0);
    $display("test1 ma write x5 done");

    // 2: LL bypass into empty FIFO
    set_idle(); ll_iss_vld = 1; ll_iss_addr = 7;
    cycle();
    set_idle(); cycle(); cycle();
    chk("t2_busy_set", busy[7], 1);
    ll_vld = 1; ll_addr = 7; ll_data = 64'h77;
    cycle();
    chk("t2_we", rf_we, 1); chk("t2_wa", rf_wa, 7); chk("t2_wd", rf_wd, 64'h77);
    chk("t2_busy_clr", busy[7], 0);
    $display("test2 ll bypass x7 done");

    // 3: MA/LL collision, MA first
    set_idle();
    ma_we = 1; ma_rd_addr = 3; ma_rd = 64'h33;
    ll_vld = 1; ll_addr = 4; ll_data = 64'h44;
    cycle();
    chk("t3_wa_ma", rf_wa, 3);
    set_idle(); cycle();
    chk("t3_we_ll", rf_we, 1); chk("t3_wa_ll", rf_wa, 4); chk("t3_wd_ll", rf_wd, 64'h44);
    cycle();
    chk("t3_drained", rf_we, 0);
    $display("test3 collision x3 then x4 done");

    // 4: FIFO fill and ordered drain
    set_idle(); ma_we = 1; ma_rd_addr = 1; ma_rd = 64'h11;
    ll_vld = 1; ll_addr = 8; ll_data = 64'h88; cycle();
    ll_addr = 9; ll_data = 64'h99; cycle();
    chk("t4_rdy_full", ll_rdy, 0); chk("t4_stall", wb_stall, 1);
    ll_addr = 10; ll_data = 64'hAA; cycle();
    ma_we = 0; cycle();
    chk("t4_first", rf_wa, 8);
    cycle();
    chk("t4_second", rf_wa, 9);
    ll_vld = 0; cycle();
    chk("t4_third", rf_wa, 10); chk("t4_third_d", rf_wd, 64'hAA);
    cycle();
    chk("t4_empty", rf_we, 0);
    $display("test4 full fifo order x8 x9 x10 done");

    // 5: x0 filtering on both sources
    set_idle(); ma_we = 1; ma_rd_addr = 0; ma_rd = 64'hDEAD;
    ll_vld = 1; ll_addr = 0; ll_data = 64'hBEEF;
    #1; chk("t5_rdy", ll_rdy, 1);
    cycle();
    chk("t5_we", rf_we, 0); chk("t5_busy", busy, 0);
    set_idle(); cycle();
    chk("t5_we2", rf_we, 0);
    $display("test5 x0 drop done");

    // 6: reset flushes FIFO and scoreboard
    ll_iss_vld = 1; ll_iss_addr = 8; cycle();
    ll_iss_addr = 9; cycle();
    set_idle(); ma_we = 1; ma_rd_addr = 2; ma_rd = 64'h22;
    ll_vld = 1; ll_addr = 8; ll_data = 64'h1; cycle();
    ll_addr = 9; ll_data = 64'h2; cycle();
    chk("t6_busy_pre", busy, 32'h300);
    set_idle(); rst = 1; cycle();
    chk("t6_busy", busy, 0); chk("t6_we", rf_we, 0);
    set_idle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t6_no_write", rf_we, 0);
    end
    $display("test6 reset flush done");

    // Randomized traffic obeying ready/valid hold and the stall response.
    for (int n = 0; n < 500; n++) begin
      logic [4:0] ia;
      rst = ($urandom_range(0, 99) == 0);
      ma_we = last_stall ? 1'b0 : 1'($urandom_range(0, 1));
      ma_rd_addr = 5'($urandom_range(0, 31));
      ma_rd = {$urandom, $urandom};
      if (!(ll_vld && !last_rdy)) begin
        ll_vld = ($urandom_range(0, 2) == 0);
        ll_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ll_data = {$urandom, $urandom};
      end
      ia = 5'($urandom_range(1, 31));
      ll_iss_vld = ($urandom_range(0, 4) == 0) && !m_busy[ia];
      ll_iss_addr = ia;
      cycle();
    end
    $display("random phase done: %0d cycles", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
